// File: rtl/spi_burst_ctrl_if.sv
// spi_burst_ctrl_if: control, FIFO and byte-engine signals of the SPI burst controller
interface spi_burst_ctrl_if #(parameter int LEN_W = 8);
  logic start, msb_first, abort, busy, done, err_udf, err_ovf;
  logic tx_wvalid, tx_wready, rx_rvalid, rx_rready;
  logic spi_ena, spi_end_trans, spi_msb_lsb;
  logic [LEN_W-1:0] len, bytes_done;
  logic [7:0] tx_wdata, rx_rdata, spi_byte_2_send, spi_byte_rcv;
  modport master(
    output start, len, msb_first, abort, tx_wdata, tx_wvalid, rx_rready, spi_byte_rcv, spi_end_trans,
    input busy, done, err_udf, err_ovf, bytes_done, tx_wready, rx_rdata, rx_rvalid,
          spi_byte_2_send, spi_ena, spi_msb_lsb
  );
  modport slave(
    input start, len, msb_first, abort, tx_wdata, tx_wvalid, rx_rready, spi_byte_rcv, spi_end_trans,
    output busy, done, err_udf, err_ovf, bytes_done, tx_wready, rx_rdata, rx_rvalid,
           spi_byte_2_send, spi_ena, spi_msb_lsb
  );
endinterface

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: sequences multi-byte SPI bursts over a byte engine with TX/RX FIFOs
module spi_burst_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W = 8
) (
  input logic clk,
  input logic arstn,
  spi_burst_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [LEN_W-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [LEN_W-1:0] len_q;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic hit, flush, accept, last, udf;

  assign tx_full = tx_cnt == CW'(FIFO_DEPTH);
  assign tx_empty = tx_cnt == '0;
  assign rx_full = rx_cnt == CW'(FIFO_DEPTH);
  assign rx_empty = rx_cnt == '0;
  assign hit = state == RUN && bus.spi_end_trans;
  assign flush = state == RUN && bus.abort;
  assign tx_push = bus.tx_wvalid && !tx_full && !flush;
  assign tx_pop = hit && !tx_empty && !flush;
  assign rx_pop = bus.rx_rready && !rx_empty;
  assign rx_push = hit && (!rx_full || rx_pop);
  assign accept = state == IDLE && bus.start && |bus.len && !tx_empty;
  assign last = bus.bytes_done + ONE == len_q;
  // only the byte being popped is left and nothing refills it this cycle
  assign udf = tx_cnt == CW'(1) && !tx_push;
  assign bus.tx_wready = !tx_full;
  assign bus.rx_rvalid = !rx_empty;
  assign bus.rx_rdata = rx_empty ? 8'h00 : rx_mem[rx_rp];
  assign bus.spi_byte_2_send = tx_empty ? 8'h00 : tx_mem[tx_rp];

  // burst sequencer with registered status outputs
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.spi_ena <= 1'b0;
      bus.spi_msb_lsb <= 1'b0;
      bus.err_udf <= 1'b0;
      bus.err_ovf <= 1'b0;
      bus.bytes_done <= '0;
      len_q <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state <= RUN;
          bus.busy <= 1'b1;
          bus.spi_ena <= 1'b1;
          bus.spi_msb_lsb <= bus.msb_first;
          bus.err_udf <= 1'b0;
          bus.err_ovf <= 1'b0;
          bus.bytes_done <= '0;
          len_q <= bus.len;
        end
        RUN: begin
          if (hit && bus.bytes_done < len_q) bus.bytes_done <= bus.bytes_done + ONE;
          if (hit && rx_full && !rx_pop) bus.err_ovf <= 1'b1;
          if (flush || (hit && (last || udf))) begin
            state <= FINISH;
            bus.spi_ena <= 1'b0;
            bus.done <= 1'b1;
            if (hit && !flush && !last) bus.err_udf <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // TX FIFO pointers; abort discards everything queued
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_cnt <= '0;
    end else if (flush) begin
      tx_rp <= tx_wp;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop) tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // RX FIFO pointers
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // FIFO storage, unreset since occupancy is tracked by the counters
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.tx_wdata;
    if (rx_push) rx_mem[rx_wp] <= bus.spi_byte_rcv;
  end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: table-driven bursts with an echo engine model and RX scoreboard
module tb_spi_burst_ctrl;
  localparam int D = 4;
  localparam int LW = 8;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  typedef struct {
    int npre;
    logic [7:0] len;
    logic msb;
    int bd;
    logic udf;
  } vec_t;
  vec_t v[6];
  logic [7:0] pat[3];

  always #5 clk = ~clk;

  spi_burst_ctrl_if #(.LEN_W(LW)) bus();
  spi_burst_ctrl #(.FIFO_DEPTH(D), .LEN_W(LW)) dut(.clk(clk), .arstn(arstn), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tx_write(input logic [7:0] b);
    bus.tx_wdata = b;
    bus.tx_wvalid = 1'b1;
    @(negedge clk);
    bus.tx_wvalid = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic start_burst(input logic [7:0] l, input logic m);
    bus.len = l;
    bus.msb_first = m;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // byte engine with MISO looped back: echoes the head it loaded; abort_at aborts mid-byte
  task automatic engine(input int abort_at, output int n);
    logic [7:0] b;
    n = 0;
    for (int g = 0; g < 16 && bus.spi_ena === 1'b1; g++) begin
      b = bus.spi_byte_2_send;
      repeat (3) @(negedge clk);
      if (n == abort_at) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        return;
      end
      repeat (3) @(negedge clk);
      chk("cs_hold", bus.spi_ena, 1);
      bus.spi_byte_rcv = b;
      bus.spi_end_trans = 1'b1;
      @(negedge clk);
      bus.spi_end_trans = 1'b0;
      n++;
    end
    chk("ena_released", bus.spi_ena, 0);
  endtask

  task automatic drain(input int cnt);
    logic [7:0] e;
    for (int i = 0; i < cnt; i++) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
      chk("rx_valid", bus.rx_rvalid, 1);
      chk("rx_data", bus.rx_rdata, e);
      bus.rx_rready = 1'b1;
      @(negedge clk);
      bus.rx_rready = 1'b0;
    end
    chk("rx_empty", bus.rx_rvalid, 0);
  endtask

  initial begin
    int n;
    bus.start = 0; bus.len = 0; bus.msb_first = 0; bus.abort = 0;
    bus.tx_wdata = 0; bus.tx_wvalid = 0; bus.rx_rready = 0;
    bus.spi_byte_rcv = 0; bus.spi_end_trans = 0;
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF;
    v[0] = '{3, 8'd3, 1'b1, 3, 1'b0};
    v[1] = '{2, 8'd2, 1'b0, 2, 1'b0};
    v[2] = '{4, 8'd4, 1'b1, 4, 1'b0};
    v[3] = '{1, 8'd1, 1'b0, 1, 1'b0};
    v[4] = '{2, 8'd5, 1'b1, 2, 1'b1};
    v[5] = '{1, 8'd4, 1'b0, 1, 1'b1};
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ena", bus.spi_ena, 0);
    chk("rst_wready", bus.tx_wready, 1);
    chk("rst_rvalid", bus.rx_rvalid, 0);
    chk("rst_bytes", bus.bytes_done, 0);
    chk("rst_flags", {bus.err_udf, bus.err_ovf}, 0);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < v[i].npre; j++) tx_write(i == 0 ? pat[j] : 8'($urandom));
      start_burst(v[i].len, v[i].msb);
      chk("busy", bus.busy, 1);
      chk("msb_lsb", bus.spi_msb_lsb, v[i].msb);
      engine(-1, n);
      chk("n_bytes", n, v[i].bd);
      chk("done", bus.done, 1);
      chk("bytes_done", bus.bytes_done, v[i].bd);
      chk("err_udf", bus.err_udf, v[i].udf);
      chk("err_ovf", bus.err_ovf, 0);
      @(negedge clk);
      chk("done_pulse", bus.done, 0);
      chk("busy_fall", bus.busy, 0);
      drain(v[i].bd);
    end

    // ignored starts: TX empty, then len=0; err_udf from the last burst must persist
    start_burst(8'd2, 1'b1);
    chk("ign_empty_busy", bus.busy, 0);
    chk("ign_empty_udf", bus.err_udf, 1);
    tx_write(8'h11);
    tx_write(8'h22);
    start_burst(8'd0, 1'b1);
    chk("ign_len0_busy", bus.busy, 0);
    chk("ign_len0_udf", bus.err_udf, 1);
    start_burst(8'd2, 1'b0);
    chk("start_clears_udf", bus.err_udf, 0);
    start_burst(8'd7, 1'b1);
    chk("ign_busy_msb", bus.spi_msb_lsb, 0);
    engine(-1, n);
    chk("ign_busy_len", bus.bytes_done, 2);
    @(negedge clk);
    drain(2);

    // overflow: RX holds 3, a 2-byte burst fills it and drops the second byte
    for (int j = 0; j < 3; j++) tx_write(8'h40 + 8'(j));
    start_burst(8'd3, 1'b1);
    engine(-1, n);
    @(negedge clk);
    tx_write(8'h77);
    tx_write(8'h88);
    start_burst(8'd2, 1'b1);
    engine(-1, n);
    chk("ovf_flag", bus.err_ovf, 1);
    chk("ovf_bytes", bus.bytes_done, 2);
    chk("ovf_done", bus.done, 1);
    void'(exp_q.pop_back());
    @(negedge clk);
    drain(4);

    // abort mid byte 2 of a 5-byte burst
    for (int j = 0; j < 4; j++) tx_write(8'h90 + 8'(j));
    start_burst(8'd5, 1'b1);
    chk("abort_clears_ovf", bus.err_ovf, 0);
    engine(1, n);
    chk("abort_done", bus.done, 1);
    chk("abort_ena", bus.spi_ena, 0);
    chk("abort_bytes", bus.bytes_done, 1);
    chk("abort_tx_empty", bus.spi_byte_2_send, 0);
    chk("abort_udf", bus.err_udf, 0);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(negedge clk);
    chk("abort_idle", bus.busy, 0);
    drain(1);

    // async reset mid-burst with RX occupied
    tx_write(8'h5A);
    start_burst(8'd1, 1'b0);
    engine(-1, n);
    @(negedge clk);
    for (int j = 0; j < 3; j++) tx_write(8'hC0 + 8'(j));
    start_burst(8'd3, 1'b1);
    repeat (3) @(negedge clk);
    #2 arstn = 1'b0;
    #1;
    chk("arst_ena", bus.spi_ena, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_rx", bus.rx_rvalid, 0);
    chk("arst_tx", bus.spi_byte_2_send, 0);
    chk("arst_msb", bus.spi_msb_lsb, 0);
    exp_q.delete();
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    tx_write(8'hE1);
    tx_write(8'h1E);
    start_burst(8'd2, 1'b0);
    engine(-1, n);
    chk("post_rst_bytes", bus.bytes_done, 2);
    chk("post_rst_flags", {bus.err_udf, bus.err_ovf}, 0);
    @(negedge clk);
    drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
